// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit that sits beside the EX-stage ALU.
// It accepts one MULT/MULTU/DIV/DIVU per start pulse and holds busy for a
// fixed latency. It then writes HI/LO and pulses done. MTHI/MTLO write HI/LO
// in a single cycle.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU, which accumulate
// into {HI,LO}. When the macro is undefined, codes 110/111 are no-ops.
module mdu_seq #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_p0;
    logic [WIDTH-1:0]     a_p0;
    logic [WIDTH-1:0]     b_p0;
    logic [2*WIDTH-1:0]   res_p0;
    logic                 op_mul;
    logic                 op_div;
    logic                 op_madd;
    logic                 accept;

    // Result of a latched operation; the accumulate forms use the current
    // HI/LO because those registers cannot change while busy.
    function automatic logic [2*WIDTH-1:0] md_result(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        logic signed [2*WIDTH-1:0] sprod;
        logic        [2*WIDTH-1:0] uprod;
        logic signed [WIDTH-1:0]   sa;
        logic signed [WIDTH-1:0]   sb;
        logic signed [WIDTH-1:0]   q;
        logic signed [WIDTH-1:0]   r;
        logic        [WIDTH-1:0]   smin;
        logic        [2*WIDTH-1:0] res;
        smin  = {1'b1, {(WIDTH-1){1'b0}}};
        sa    = a;
        sb    = b;
        sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        q     = '0;
        r     = '0;
        case (op)
            OP_MULT:  res = sprod;
            OP_MULTU: res = uprod;
            OP_MADD:  res = {hi, lo} + sprod;
            OP_MADDU: res = {hi, lo} + uprod;
            OP_DIVU: begin
                if (b == '0) res = {a, {WIDTH{1'b1}}};
                else         res = {a % b, a / b};
            end
            OP_DIV: begin
                if (b == '0) begin
                    res = {a, {WIDTH{1'b1}}};
                end else if (a == smin && b == {WIDTH{1'b1}}) begin
                    // The quotient is not representable, so LO keeps the dividend.
                    res = {{WIDTH{1'b0}}, a};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r, q};
                end
            end
            default:  res = {hi, lo};
        endcase
        return res;
    endfunction

    // Decode which opcodes start a multi-cycle operation
    always_comb begin
        op_mul  = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
        op_div  = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
`ifdef MDU_MADD_EN
        op_madd = (MDOp == OP_MADD) || (MDOp == OP_MADDU);
`else
        op_madd = 1'b0;
`endif
        accept  = start && (state == IDLE) && (op_mul || op_div || op_madd);
    end

    // Capture opcode and operands on the acceptance edge
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= MDOp;
            a_p0  <= A;
            b_p0  <= B;
        end
    end

    // Compute the result from the latched operands
    always_comb begin
        res_p0 = md_result(op_p0, a_p0, b_p0, HI, LO);
    end

    // Control FSM plus the HI/LO registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_mul || op_madd) begin
                            state <= BUSY;
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(MUL_LAT);
                        end else if (op_div) begin
                            state <= BUSY;
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(DIV_LAT);
                        end else if (MDOp == OP_MTHI) begin
                            HI <= A;
                        end else if (MDOp == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        {HI, LO} <= res_p0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq with a behavioural reference model.
module tb_mdu_seq;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  MDOp = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu_seq #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .MDOp(MDOp),
        .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hilo;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          nchk = 0;
    int          nerr = 0;
    int          bcnt = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    function automatic bit is_md(input logic [2:0] op);
        if (op <= 3'd3) return 1'b1;
`ifdef MDU_MADD_EN
        if (op >= 3'd6) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Architectural meaning of each operation, in plain integer arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        int          sa, sb, q, r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'h0, a} * {32'h0, b};
        case (op)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                sa = a; sb = b;
                q = sa / sb;
                r = sa - q * sb;
                return {r, q};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd6: return {hi, lo} + sp;
            3'd7: return {hi, lo} + up;
            default: return {hi, lo};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!reset_n) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (sbq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL spurious_done: done=1 with no operation outstanding");
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_hi", 64'(HI), 64'(mon_e.hilo[63:32]));
                    check("sb_lo", 64'(LO), 64'(mon_e.hilo[31:0]));
                    check("sb_latency", 64'(bcnt), 64'(mon_e.lat));
                end
                bcnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (busy && g < 100) begin
            tick();
            g++;
        end
        if (busy) begin
            nchk++;
            nerr++;
            $display("FAIL %s_timeout: busy still 1 after 100 cycles, expected 0", name);
        end
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        check({name, "_hi"}, 64'(HI), 64'(hi));
        check({name, "_lo"}, 64'(LO), 64'(lo));
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise);
        exp_t e;
        int   g;
        wait_idle("issue");
        MDOp  = op;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (is_md(op)) begin
            e.hilo = ref_md(op, a, b, mhi, mlo);
            e.lat  = (op == 3'd2 || op == 3'd3) ? DIV_LAT : MUL_LAT;
            sbq.push_back(e);
            {mhi, mlo} = e.hilo;
            check("accept_busy", 64'(busy), 64'd1);
            if (noise) begin
                // Random starts while busy must all be ignored
                g = 0;
                while (busy && g < 100) begin
                    start = 1'($urandom_range(0, 1));
                    MDOp  = 3'($urandom_range(0, 7));
                    A     = $urandom;
                    B     = $urandom;
                    tick();
                    g++;
                end
                start = 1'b0;
            end
        end else begin
            if (op == 3'd4) mhi = a;
            else if (op == 3'd5) mlo = a;
            check("imm_busy", 64'(busy), 64'd0);
            check("imm_done", 64'(done), 64'd0);
            expect_hilo("imm", mhi, mlo);
        end
    endtask

    initial begin
        int g;
        // Reset state
        reset_n = 1'b0;
        tick();
        tick();
        expect_hilo("reset", 32'h0, 32'h0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset_n = 1'b1;

        // MULT -3 * 7
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_idle("mult");
        check("mult_done", 64'(done), 64'd1);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
        check("done_width", 64'(done), 64'd0);

        // Signed and unsigned division corner cases
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle("div");
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd3, 32'd7, 32'd0, 1'b0);
        wait_idle("divu0");
        expect_hilo("divu0", 32'd7, 32'hFFFF_FFFF);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle("divovf");
        expect_hilo("divovf", 32'h0, 32'h8000_0000);
        issue(3'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
        wait_idle("div0");
        expect_hilo("div0", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MULTU with MTHI held on start: ignored while busy and on the done edge, taken one cycle later
        issue(3'd1, 32'h8, 32'hF, 1'b0);
        MDOp  = 3'd4;
        A     = 32'h55;
        B     = 32'h0;
        start = 1'b1;
        g = 0;
        while (!done && g < 100) begin
            tick();
            g++;
        end
        check("b2b_done_seen", 64'(done), 64'd1);
        expect_hilo("b2b", 32'h0, 32'h78);
        check("b2b_idle", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        mhi   = 32'h55;
        expect_hilo("b2b_next", 32'h55, 32'h78);

        // MTLO while idle
        issue(3'd5, 32'h1234, 32'h0, 1'b0);

        // MADDU accumulation, or a no-op without the option
        issue(3'd4, 32'h0, 32'h0, 1'b0);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
        issue(3'd7, 32'd1, 32'd1, 1'b0);
        wait_idle("maddu");
`ifdef MDU_MADD_EN
        expect_hilo("maddu", 32'h1, 32'h0);
`else
        expect_hilo("maddu", 32'h0, 32'hFFFF_FFFF);
`endif

        // Reset mid-DIV aborts the operation
        issue(3'd2, 32'd100, 32'd3, 1'b0);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        expect_hilo("abort", 32'h0, 32'h0);
        check("abort_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        sbq.delete();
        mhi = '0;
        mlo = '0;
        repeat (DIV_LAT + 3) tick();
        expect_hilo("abort_after", 32'h0, 32'h0);

        // Randomised operations with optional noise starts while busy
        repeat (80) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
        wait_idle("final");
        tick();
        tick();
        check("sb_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
